// File: rtl/max7219_cascade_ctrl.sv
// Command FIFO and frame sequencer upstream of max7219_if.
// Each buffered register write becomes one 16-bit frame per cascaded device.
module max7219_cascade_ctrl #(
    parameter int G_NB_MATRIX  = 4,
    parameter int G_FIFO_DEPTH = 8,
    parameter int G_DEV_WIDTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [G_DEV_WIDTH-1:0] i_cmd_dev,
    input  logic                   i_cmd_bcast,
    input  logic [3:0]             i_cmd_reg,
    input  logic [7:0]             i_cmd_data,
    output logic                   o_start,
    output logic                   o_en_load,
    output logic [15:0]            o_data,
    input  logic                   i_done,
    output logic                   o_busy
);

    localparam int A_W = (G_FIFO_DEPTH > 1) ? $clog2(G_FIFO_DEPTH) : 1;
    localparam int J_W = (G_NB_MATRIX > 1) ? $clog2(G_NB_MATRIX) : 1;
    localparam int E_W = 1 + G_DEV_WIDTH + 12;
    localparam logic [J_W-1:0] J_LAST   = J_W'(G_NB_MATRIX - 1);
    localparam logic [A_W:0]   FULL_CNT = (A_W+1)'(G_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    state_t state, state_nx;

    logic [E_W-1:0]         mem [G_FIFO_DEPTH];
    logic [A_W-1:0]         wr_ptr, rd_ptr;
    logic [A_W:0]           count;
    logic                   empty, full, push, pop;

    logic                   head_bcast;
    logic [G_DEV_WIDTH-1:0] head_dev;
    logic [3:0]             head_reg;
    logic [7:0]             head_data;

    logic                   cmd_bcast;
    logic [G_DEV_WIDTH-1:0] cmd_dev;
    logic [3:0]             cmd_reg;
    logic [7:0]             cmd_data;

    logic [J_W-1:0]         j;
    logic [15:0]            data_q;
    logic                   load_q;
    logic                   advance;

    // Frame jj is shifted first and lands farthest down the chain.
    function automatic logic [15:0] frame_word(
        input logic                   bc,
        input logic [G_DEV_WIDTH-1:0] dv,
        input logic [3:0]             rg,
        input logic [7:0]             dt,
        input logic [J_W-1:0]         jj
    );
        if (bc || (int'(dv) == G_NB_MATRIX - 1 - int'(jj)))
            return {4'h0, rg, dt};
        return 16'h0000;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign push  = i_cmd_valid && !full;
    assign pop   = (state == IDLE) && !empty;
    assign advance = (state == WAIT_DONE) && i_done && (j != J_LAST);

    assign {head_bcast, head_dev, head_reg, head_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {i_cmd_bcast, i_cmd_dev, i_cmd_reg, i_cmd_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!empty) state_nx = START;
            START:     state_nx = WAIT_DONE;
            WAIT_DONE: if (i_done) state_nx = (j == J_LAST) ? IDLE : START;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            cmd_bcast <= head_bcast;
            cmd_dev   <= head_dev;
            cmd_reg   <= head_reg;
            cmd_data  <= head_data;
        end
    end

    // Frame word and load flag are prepared one edge ahead of each START
    // and then held through the completing i_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j      <= '0;
            data_q <= 16'h0000;
            load_q <= 1'b0;
        end else if (pop) begin
            j      <= '0;
            data_q <= frame_word(head_bcast, head_dev, head_reg, head_data, '0);
            load_q <= (J_LAST == '0);
        end else if (advance) begin
            j      <= j + 1'b1;
            data_q <= frame_word(cmd_bcast, cmd_dev, cmd_reg, cmd_data, j + 1'b1);
            load_q <= ((j + 1'b1) == J_LAST);
        end
    end

    assign o_start     = (state == START);
    assign o_en_load   = load_q;
    assign o_data      = data_q;
    assign o_busy      = !empty || (state != IDLE);
    assign o_cmd_ready = !full;

endmodule

// File: tb/tb_max7219_cascade_ctrl.sv
// Directed bench for max7219_cascade_ctrl: frames, load placement, FIFO fill, gaps, async reset.
module tb_max7219_cascade_ctrl;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd_dev = '0;
    logic        i_cmd_bcast = 1'b0;
    logic [3:0]  i_cmd_reg = '0;
    logic [7:0]  i_cmd_data = '0;
    logic        o_start, o_en_load, o_busy;
    logic [15:0] o_data;
    logic        i_done = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_delay = 1;
    int dq[$];
    logic [16:0] fr_q[$];
    int fr_cyc[$];
    logic [16:0] exp_q[$];
    logic        act = 1'b0;
    logic [15:0] ref_d;
    logic        ref_l;

    max7219_cascade_ctrl #(.G_NB_MATRIX(NB), .G_FIFO_DEPTH(8), .G_DEV_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_dev(i_cmd_dev), .i_cmd_bcast(i_cmd_bcast),
        .i_cmd_reg(i_cmd_reg), .i_cmd_data(i_cmd_data),
        .o_start(o_start), .o_en_load(o_en_load), .o_data(o_data),
        .i_done(i_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Frame monitor: records each start pulse and verifies the frame held until its done.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            act = 1'b0;
        end else begin
            if (act && i_done) begin
                check("hold_data", {16'h0, o_data}, {16'h0, ref_d});
                check("hold_load", {31'h0, o_en_load}, {31'h0, ref_l});
                act = 1'b0;
            end
            if (o_start) begin
                fr_q.push_back({o_en_load, o_data});
                fr_cyc.push_back(cyc);
                ref_d = o_data;
                ref_l = o_en_load;
                act = 1'b1;
            end
        end
    end

    // max7219_if stand-in: answers each start with a done pulse after a per-frame delay.
    initial forever begin
        int d;
        @(negedge clk);
        if (o_start && rst_n) begin
            d = (dq.size() > 0) ? dq.pop_front() : done_delay;
            repeat (d) @(posedge clk);
            #1 i_done = 1'b1;
            @(posedge clk);
            #1 i_done = 1'b0;
        end
    end

    task automatic push(input logic b, input logic [2:0] d, input logic [3:0] r, input logic [7:0] v);
        int n = 0;
        i_cmd_bcast = b; i_cmd_dev = d; i_cmd_reg = r; i_cmd_data = v;
        i_cmd_valid = 1'b1;
        while (!o_cmd_ready && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 500) check("push_timeout", {31'h0, o_cmd_ready}, 32'h1);
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (fr_q.size() < n && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 3000) check("frame_timeout", fr_q.size(), n);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (o_busy && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        check("idle", {31'h0, o_busy}, 32'h0);
    endtask

    task automatic cmp_frames(input string tag);
        check({tag, "_count"}, fr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < fr_q.size(); i++)
            check(tag, {15'h0, fr_q[i]}, {15'h0, exp_q[i]});
        fr_q.delete(); fr_cyc.delete(); exp_q.delete();
    endtask

    function automatic void add_exp(input logic b, input int d, input logic [3:0] r, input logic [7:0] v);
        for (int k = 0; k < NB; k++) begin
            logic hit;
            hit = b || (d == NB - 1 - k);
            exp_q.push_back({(k == NB - 1), hit ? {4'h0, r, v} : 16'h0000});
        end
    endfunction

    initial begin
        int acc;
        #2 rst_n = 1'b0;
        #1;
        check("rst_start", {31'h0, o_start}, 32'h0);
        check("rst_load", {31'h0, o_en_load}, 32'h0);
        check("rst_data", {16'h0, o_data}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        check("rst_ready", {31'h0, o_cmd_ready}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // dev 0 is written by the last frame shifted
        push(1'b0, 3'd0, 4'hA, 8'h05);
        check("busy_after_push", {31'h0, o_busy}, 32'h1);
        wait_frames(4);
        wait_idle();
        exp_q = '{17'h00000, 17'h00000, 17'h00000, 17'h10A05};
        cmp_frames("dev0");

        push(1'b1, 3'd2, 4'hC, 8'h01);
        wait_frames(4);
        wait_idle();
        exp_q = '{17'h00C01, 17'h00C01, 17'h00C01, 17'h10C01};
        cmp_frames("bcast");

        push(1'b0, 3'd5, 4'h3, 8'h7E);
        wait_frames(4);
        wait_idle();
        exp_q = '{17'h00000, 17'h00000, 17'h00000, 17'h10000};
        cmp_frames("dev5");

        push(1'b0, 3'd3, 4'h1, 8'h81);
        push(1'b0, 3'd1, 4'h2, 8'h42);
        wait_frames(8);
        wait_idle();
        for (int i = 0; i < 7 && fr_cyc.size() == 8; i++)
            check("gap", fr_cyc[i+1] - fr_cyc[i], (i == 3) ? 3 : 2);
        exp_q = '{17'h00181, 17'h00000, 17'h00000, 17'h10000,
                  17'h00000, 17'h00000, 17'h00242, 17'h10000};
        cmp_frames("gap_frames");

        dq.push_back(40);
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            if (o_cmd_ready) acc++;
            push(i == 4, 3'(i % 4), 4'(i + 1), 8'(8'h10 + i));
            add_exp(i == 4, i % 4, 4'(i + 1), 8'(8'h10 + i));
        end
        check("accepted", acc, 9);
        check("ready_full", {31'h0, o_cmd_ready}, 32'h0);
        i_cmd_bcast = 1'b1; i_cmd_reg = 4'hF; i_cmd_data = 8'hEE; i_cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        wait_frames(36);
        wait_idle();
        check("ready_back", {31'h0, o_cmd_ready}, 32'h1);
        cmp_frames("fill9");

        dq.push_back(1);
        dq.push_back(60);
        push(1'b1, 3'd0, 4'h9, 8'h11);
        push(1'b0, 3'd1, 4'h9, 8'h22);
        push(1'b0, 3'd2, 4'h9, 8'h33);
        push(1'b0, 3'd3, 4'h9, 8'h44);
        wait_frames(2);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'h0, o_busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_start", {31'h0, o_start}, 32'h0);
        check("mid_rst_load", {31'h0, o_en_load}, 32'h0);
        check("mid_rst_data", {16'h0, o_data}, 32'h0);
        check("mid_rst_busy", {31'h0, o_busy}, 32'h0);
        check("mid_rst_ready", {31'h0, o_cmd_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        check("stray_done", fr_q.size(), 2);
        check("post_rst_busy", {31'h0, o_busy}, 32'h0);
        fr_q.delete(); fr_cyc.delete();

        push(1'b0, 3'd2, 4'h4, 8'hA5);
        wait_frames(4);
        wait_idle();
        exp_q = '{17'h00000, 17'h004A5, 17'h00000, 17'h10000};
        cmp_frames("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/max7219_cascade_ctrl.md
# max7219_cascade_ctrl

Command sequencer sitting directly upstream of `max7219_if`. It buffers register-write commands for a chain of cascaded MAX7219 devices in a small FIFO. Each command is expanded into one 16-bit frame per device: the target register write for the addressed device(s), and no-op frames (0x0000) for all others. Frames are issued one at a time through the `max7219_if` start/done handshake, with the load strobe enabled only on the last frame.

## Interface
- G_NB_MATRIX, 4, number of cascaded MAX7219 devices (1..16)
- G_FIFO_DEPTH, 8, command FIFO depth (power of two, ≥2)
- G_DEV_WIDTH, 2, width of device index (≥1, ≥ceil(log2(G_NB_MATRIX)))
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  FIFO not full; command accepted on an edge where valid&ready
- i_cmd_dev  in  G_DEV_WIDTH  target device index (0 = device wired to controller DIN)
- i_cmd_bcast  in  1  1: write the register in every device; i_cmd_dev ignored
- i_cmd_reg  in  4  MAX7219 register address
- i_cmd_data  in  8  register data
- o_start  out  1  one-cycle frame start pulse to max7219_if
- o_en_load  out  1  load enable for the current frame, to max7219_if
- o_data  out  16  frame to max7219_if
- i_done  in  1  one-cycle frame-complete pulse from max7219_if
- o_busy  out  1  FIFO non-empty or FSM not in IDLE

## Operation
- FIFO stores {bcast, dev, reg, data}. Push on valid&ready. Pop only from IDLE when non-empty. No push when full (ready low). A pop and push in the same edge are both honoured.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the command register, clear frame counter j, go to START.
  - START: o_start=1 for exactly this cycle; go to WAIT_DONE.
  - WAIT_DONE: on i_done, if j==G_NB_MATRIX-1 go to IDLE, else increment j and go to START.
- Frame j targets device G_NB_MATRIX-1-j, because the first frame shifted ends up farthest down the chain.
- o_data for frame j = {4'h0, reg, data} if bcast, or if dev==G_NB_MATRIX-1-j; otherwise 16'h0000.
- o_en_load = 1 only when j==G_NB_MATRIX-1.
- dev ≥ G_NB_MATRIX: all G_NB_MATRIX frames are no-ops, and load still pulses on the last frame. No error is raised.
- o_data and o_en_load are registered, valid from the START cycle, and held stable until the cycle after the i_done that completes the frame.
- i_done outside WAIT_DONE is ignored.
- Reset (asynchronous, any time including mid-frame):
  - FSM to IDLE, FIFO emptied, j=0.
  - o_start=0, o_en_load=0, o_data=0, o_busy=0, o_cmd_ready=1.
  - A partially shifted chain is not repaired; the next command rewrites all devices in full.

## Timing
- Command accepted on edge k with FIFO empty and FSM in IDLE: pop on edge k+1; o_start high in the cycle after edge k+1.
- Frame-to-frame: o_start of frame j+1 is high in the cycle after the cycle in which i_done is high.
- After the last frame's i_done: one IDLE cycle, then the next pop, giving a 2-cycle gap to the next o_start.
- Per command: exactly G_NB_MATRIX o_start pulses, and exactly one with o_en_load=1.
- o_busy deasserts in the first IDLE cycle with the FIFO empty.
- o_cmd_ready falls in the cycle after the push that fills the FIFO, and rises in the cycle after the next pop.

## Test plan
- G_NB_MATRIX=4, cmd dev=0 reg=0xA data=0x05 -> frames 0x0000, 0x0000, 0x0000, 0x0A05; en_load only on the 4th; one load seen by the SPI checker.
- Broadcast reg=0xC data=0x01 -> four frames of 0x0C01, en_load on the 4th only.
- Push 9 commands back-to-back while the first frame is stalled (delayed i_done) -> 9 accepted, since 1 pops immediately and 8 fill the FIFO; ready low at the 10th; all 9×4 frames emitted in order.
- Assert rst_n=0 while in WAIT_DONE of frame 2 with 3 commands queued -> outputs at reset values immediately, o_busy=0; a stray i_done afterwards produces no o_start.
- dev=5 with G_NB_MATRIX=4 -> four 0x0000 frames, en_load on the last.
- Two commands queued, i_done delivered one cycle after each o_start -> o_start gaps of 2 cycles within a command and 3 cycles between commands; o_data stable between each o_start and its i_done.
